// File: rtl/count_job_arbiter_if.sv
// count_job_arbiter_if: requester bus and status outputs of the shared count engine
interface count_job_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_len;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic [2:0]             done_id;
  logic [CNT_W-1:0]       cnt_value;
  logic [1:0]             state_out;
  logic [7:0]             led_code;
  modport master (
    output req, req_len,
    input  gnt, busy, done, aborted, done_id, cnt_value, state_out, led_code
  );
  modport slave (
    input  req, req_len,
    output gnt, busy, done, aborted, done_id, cnt_value, state_out, led_code
  );
endinterface

// File: rtl/count_job_arbiter.sv
// count_job_arbiter: round-robin sharing of one count engine between N_REQ requesters
module count_job_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  count_job_arbiter_if.slave      bus
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, COUNT = 2'b10, DONE = 2'b11} state_t;
  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [IW-1:0]    owner_q, owner_d, ptr_q, ptr_d, pick, idx;
  logic             abort_q, abort_d;
  // first requester above the last-grant pointer, wrapping; downward scan so the nearest wins
  always_comb begin
    pick = ptr_q;
    idx  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr_q) + i) % N_REQ);
      if (bus.req[idx]) pick = idx;
    end
  end
  // job sequencing: IDLE -> LOAD -> COUNT -> DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        owner_d = pick;
        ptr_d   = pick;
        len_d   = bus.req_len[int'(pick)*CNT_W +: CNT_W];
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = (len_q == '0) ? DONE : COUNT;
      end
      COUNT: if (!bus.req[owner_q]) begin
        abort_d = 1'b1;
        state_d = DONE;
      end else if (cnt_q == len_q - CNT_W'(1)) begin
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset wins over ena, ena=0 freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      abort_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end
  assign bus.gnt       = (state_q == IDLE) ? '0 : (N_REQ'(1) << owner_q);
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.aborted   = (state_q == DONE) && abort_q;
  assign bus.done_id   = 3'(owner_q);
  assign bus.cnt_value = cnt_q;
  assign bus.state_out = state_q;
  assign bus.led_code  = state_q == IDLE ? 8'd10 : state_q == LOAD ? 8'd3 : state_q == COUNT ? 8'd5 : 8'd15;
endmodule

// File: tb/tb_count_job_arbiter.sv
// tb_count_job_arbiter: scoreboard bench for the round-robin count engine
module tb_count_job_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  typedef struct {int id; int ab; int cnt; int cyc;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ena;
  logic stall = 1'b0;
  logic rnd_ena = 1'b0;
  int   cyc = 0;
  int   last_cyc = -1;
  int   m_ptr = N - 1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t me;
  count_job_arbiter_if #(.N_REQ(N), .CNT_W(W)) bus ();
  count_job_arbiter #(.N_REQ(N), .CNT_W(W)) dut (.clk(clk), .reset(reset), .ena(ena), .bus(bus));
  always #5 clk = ~clk;
  // active-cycle counter: only clock edges the design actually acts on
  always @(posedge clk) if (!reset && ena) cyc <= cyc + 1;
  always @(negedge clk) ena = stall ? 1'b0 : rnd_ena ? ($urandom_range(3) != 0) : 1'b1;
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // monitor: every fresh done pulse is matched against the oldest predicted job
  always @(negedge clk) begin
    if (!reset && bus.done && cyc != last_cyc) begin
      last_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending job", cyc);
      end else begin
        me = sb.pop_front();
        chk("sb_done_id", int'(bus.done_id), me.id);
        chk("sb_aborted", int'(bus.aborted), me.ab);
        chk("sb_cnt", int'(bus.cnt_value), me.cnt);
        chk("sb_done_cycle", cyc, me.cyc);
        chk("sb_gnt", int'(bus.gnt), 1 << me.id);
      end
    end
  end
  // one job from the reference rules: winner, per-cycle phase, and the predicted done
  task automatic run_job(input logic [N-1:0] mask, input logic [N*W-1:0] lens, input int ab);
    int w, L, n, d, t, st, g, k, idx;
    exp_t e;
    bit aborting;
    w = -1;
    for (int i = 1; i <= N; i++) begin
      idx = (m_ptr + i) % N;
      if (w < 0 && ((int'(mask) >> idx) & 1) == 1) w = idx;
    end
    m_ptr = w;
    L = int'(lens >> (W * w)) & ((1 << W) - 1);
    k = (ab < 0 || L == 0) ? -1 : ab % L;
    aborting = k >= 0;
    n = cyc;
    d = L == 0 ? n + 2 : aborting ? n + 3 + k : n + 2 + L;
    e.id = w; e.ab = aborting ? 1 : 0; e.cnt = L == 0 ? 0 : aborting ? k : L - 1; e.cyc = d;
    sb.push_back(e);
    bus.req = mask;
    bus.req_len = lens;
    g = 0;
    while (1) begin
      @(negedge clk);
      t = cyc;
      st = t <= n ? 0 : t == n + 1 ? 1 : t < d ? 2 : t == d ? 3 : 0;
      chk("state_out", int'(bus.state_out), st);
      chk("led_code", int'(bus.led_code), st == 0 ? 10 : st == 1 ? 3 : st == 2 ? 5 : 15);
      chk("gnt", int'(bus.gnt), st != 0 ? (1 << w) : 0);
      chk("busy", int'(bus.busy), st != 0 ? 1 : 0);
      if (st == 2) chk("cnt_value", int'(bus.cnt_value), t - n - 2);
      if (st != 0) chk("done_id", int'(bus.done_id), w);
      if (aborting && t == n + 2 + k) bus.req = bus.req & ~(N'(1) << w);
      if (t > d) break;
      if (++g > 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL job_timeout: cycle %0d, expected done by %0d", t, d);
        break;
      end
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = N - 1;
  endtask
  initial begin
    int n0, g;
    bus.req = '0;
    bus.req_len = '0;
    do_reset();
    chk("rst_state", int'(bus.state_out), 0);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_led", int'(bus.led_code), 10);
    chk("rst_cnt", int'(bus.cnt_value), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aborted", int'(bus.aborted), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    run_job(4'b0001, 16'h0003, -1);
    do_reset();
    for (int i = 0; i < 5; i++) run_job(4'b1111, 16'h1111, -1);
    run_job(4'b0001, 16'h0008, 2);
    run_job(4'b0100, 16'h0000, -1);
    n0 = cyc;
    fork
      run_job(4'b0010, 16'h0060, -1);
      begin
        g = 0;
        while (cyc < n0 + 4 && g < 100) begin @(negedge clk); g++; end
        stall = 1'b1;
        repeat (4) @(negedge clk);
        stall = 1'b0;
      end
    join
    n0 = cyc;
    bus.req_len = 16'h000A;
    bus.req = 4'b0001;
    g = 0;
    while (cyc < n0 + 7 && g < 100) begin @(negedge clk); g++; end
    chk("t6_cnt_before", int'(bus.cnt_value), 5);
    chk("t6_state_before", int'(bus.state_out), 2);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("t6_state", int'(bus.state_out), 0);
    chk("t6_cnt", int'(bus.cnt_value), 0);
    chk("t6_gnt", int'(bus.gnt), 0);
    chk("t6_done", int'(bus.done), 0);
    reset = 1'b0;
    m_ptr = N - 1;
    run_job(4'b1111, 16'h2222, -1);
    rnd_ena = 1'b1;
    for (int i = 0; i < 40; i++)
      run_job(4'($urandom_range(1, 15)), 16'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(14)) : -1);
    rnd_ena = 1'b0;
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
